// File: rtl/mem_rep_sequencer_if.sv
// Purpose : signal bundle between the RR/latch stage, the REP sequencer and the mem stage.
// Latency : none; this is wiring only.
// Backpressure: upstream holds its latch while busy | stall_in. Mem stage stalls via stall_in.
// Ports: upstream instruction (valid_in, is_rep_in, rep_num, opsize_in, df_in,
//        mem_addr1_in, mem_addr2_in), pipeline control (stall_in, flush), and
//        mem-stage iteration outputs (seq_valid, mem_addr*_out, iter_cnt_out,
//        last_iter, busy, done).
// slave  = the sequencer's view; master = the view of the upstream and mem-stage driver.
interface mem_rep_sequencer_if #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 32
);
  logic              valid_in;
  logic              is_rep_in;
  logic [CNT_W-1:0]  rep_num;
  logic [1:0]        opsize_in;
  logic              df_in;
  logic [ADDR_W-1:0] mem_addr1_in;
  logic [ADDR_W-1:0] mem_addr2_in;
  logic              stall_in;
  logic              flush;
  logic              seq_valid;
  logic [ADDR_W-1:0] mem_addr1_out;
  logic [ADDR_W-1:0] mem_addr2_out;
  logic [CNT_W-1:0]  iter_cnt_out;
  logic              last_iter;
  logic              busy;
  logic              done;

  modport slave (
    input  valid_in, is_rep_in, rep_num, opsize_in, df_in,
           mem_addr1_in, mem_addr2_in, stall_in, flush,
    output seq_valid, mem_addr1_out, mem_addr2_out, iter_cnt_out,
           last_iter, busy, done
  );

  modport master (
    output valid_in, is_rep_in, rep_num, opsize_in, df_in,
           mem_addr1_in, mem_addr2_in, stall_in, flush,
    input  seq_valid, mem_addr1_out, mem_addr2_out, iter_cnt_out,
           last_iter, busy, done
  );
endinterface

// File: rtl/mem_rep_sequencer.sv
// Purpose : expands a REP string instruction into one mem-stage iteration per accepted cycle.
// Latency : the first iteration (and any non-REP instruction) passes through in the same cycle.
//           done pulses one cycle after the final accept.
// Backpressure: stall_in freezes the current iteration. busy holds the upstream latch until the last accept.
// Ports: clk, clr (async active-low reset), bus (mem_rep_sequencer_if.slave).
module mem_rep_sequencer #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 32
) (
  input  logic               clk,
  input  logic               clr,
  mem_rep_sequencer_if.slave bus
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;      // iterations still to issue, including the presented one
  logic [ADDR_W-1:0] addr1_q;
  logic [ADDR_W-1:0] addr2_q;
  logic [1:0]        size_q;
  logic              df_q;
  logic              done_q;

  logic              seq_valid;
  logic              busy;
  logic              last_iter;
  logic [CNT_W-1:0]  iter_cnt;
  logic [ADDR_W-1:0] addr1_out;
  logic [ADDR_W-1:0] addr2_out;
  logic              accept;
  logic              rep_req;
  logic              rep_zero;
  logic              rep_multi;

  function automatic logic [ADDR_W-1:0] step_addr(input logic [ADDR_W-1:0] addr,
                                                   input logic [1:0]        size,
                                                   input logic              dec);
    logic [ADDR_W-1:0] step;
    step = ADDR_W'(1) << size;
    return dec ? (addr - step) : (addr + step);
  endfunction

  assign rep_req   = bus.valid_in & bus.is_rep_in;
  assign rep_zero  = rep_req & (bus.rep_num == '0);
  assign rep_multi = rep_req & (bus.rep_num > CNT_W'(1));
  assign accept    = seq_valid & ~bus.stall_in & ~bus.flush;

  // State register
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. A flush in IDLE needs no special case because accept is already low.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept && rep_multi) state_d = RUN;
      RUN: begin
        if (bus.flush)                 state_d = IDLE;
        else if (accept && last_iter) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic. In IDLE the first iteration is presented straight from the inputs.
  // In RUN the iteration is presented from the registers.
  always_comb begin
    seq_valid = 1'b0;
    busy      = 1'b0;
    last_iter = 1'b0;
    iter_cnt  = '0;
    addr1_out = bus.mem_addr1_in;
    addr2_out = bus.mem_addr2_in;
    case (state_q)
      IDLE: begin
        if (!bus.flush && bus.valid_in) begin
          if (!bus.is_rep_in) begin
            seq_valid = 1'b1;
            last_iter = 1'b1;
          end else if (!rep_zero) begin
            seq_valid = 1'b1;
            iter_cnt  = bus.rep_num - CNT_W'(1);
            last_iter = (bus.rep_num == CNT_W'(1));
            busy      = rep_multi;
          end
        end
      end
      RUN: begin
        addr1_out = addr1_q;
        addr2_out = addr2_q;
        if (!bus.flush) begin
          seq_valid = 1'b1;
          iter_cnt  = cnt_q - CNT_W'(1);
          last_iter = (cnt_q == CNT_W'(1));
          // Drop busy in the cycle the last iteration is accepted, so that the
          // upstream latch advances on that same edge.
          busy      = ~(last_iter & ~bus.stall_in);
        end
      end
      default: ;
    endcase
  end

  // Sequence datapath: count, stepped addresses, captured size and direction, done pulse.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      cnt_q   <= '0;
      addr1_q <= '0;
      addr2_q <= '0;
      size_q  <= 2'b00;
      df_q    <= 1'b0;
      done_q  <= 1'b0;
    end else if (bus.flush) begin
      cnt_q   <= '0;
      addr1_q <= '0;
      addr2_q <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept && rep_req) begin
            if (rep_multi) begin
              cnt_q   <= bus.rep_num - CNT_W'(1);
              addr1_q <= step_addr(bus.mem_addr1_in, bus.opsize_in, bus.df_in);
              addr2_q <= step_addr(bus.mem_addr2_in, bus.opsize_in, bus.df_in);
              size_q  <= bus.opsize_in;
              df_q    <= bus.df_in;
            end else begin
              done_q <= 1'b1;
            end
          end else if (rep_zero && !bus.stall_in) begin
            // A zero-count REP is consumed with no memory access.
            done_q <= 1'b1;
          end
        end
        RUN: begin
          if (accept) begin
            cnt_q   <= cnt_q - CNT_W'(1);
            addr1_q <= step_addr(addr1_q, size_q, df_q);
            addr2_q <= step_addr(addr2_q, size_q, df_q);
            if (last_iter) done_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.seq_valid     = seq_valid;
  assign bus.busy          = busy;
  assign bus.last_iter     = last_iter;
  assign bus.iter_cnt_out  = iter_cnt;
  assign bus.mem_addr1_out = addr1_out;
  assign bus.mem_addr2_out = addr2_out;
  assign bus.done          = done_q;

endmodule

// File: tb/tb_mem_rep_sequencer.sv
// Purpose : self-checking bench for mem_rep_sequencer.
//           Each instruction's iteration trace is predicted from the count, size, direction and stall pattern.
// Ports   : none. It instantiates mem_rep_sequencer_if and mem_rep_sequencer.
module tb_mem_rep_sequencer;

  logic clk = 1'b0;
  logic clr = 1'b0;
  int   tests = 0;
  int   fails = 0;
  bit   exp_done = 1'b0;  // done expected during the next observed cycle

  mem_rep_sequencer_if #(.ADDR_W(32), .CNT_W(32)) bus ();

  mem_rep_sequencer #(.ADDR_W(32), .CNT_W(32)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  // Present one instruction and hold it, as the upstream latch would, until it is consumed.
  // Expected iteration k: addresses base +/- k*step, count n-1-k, last when k == n-1.
  task automatic exec_instr(input bit rep, input logic [31:0] n, input logic [1:0] sz,
                            input bit df, input logic [31:0] a1, input logic [31:0] a2,
                            input int stall_pct, input logic [31:0] stall_k,
                            input int stall_len, input string tag);
    logic [31:0] k;
    logic [31:0] step;
    logic [35:0] e_flags, o_flags;
    logic [63:0] e_addr, o_addr;
    int   held;
    int   guard;
    bit   fin;
    bit   stall;
    k = 0; held = 0; guard = 0; fin = 0;
    step = 32'd1 << sz;
    bus.valid_in = 1'b1; bus.is_rep_in = rep; bus.rep_num = n; bus.opsize_in = sz;
    bus.df_in = df; bus.mem_addr1_in = a1; bus.mem_addr2_in = a2; bus.flush = 1'b0;
    while (!fin) begin
      stall = (int'($urandom_range(0, 99)) < stall_pct);
      if (k == stall_k && held < stall_len) begin
        stall = 1'b1;
        held++;
      end
      bus.stall_in = stall;
      @(negedge clk);
      if (rep && n == 0)
        e_flags = {1'b0, 1'b0, 1'b0, exp_done, 32'd0};
      else if (!rep)
        e_flags = {1'b1, 1'b0, 1'b1, exp_done, 32'd0};
      else
        e_flags = {1'b1, (n > 1 && !(k == n - 1 && !stall)), (k == n - 1), exp_done, n - 1 - k};
      e_addr = df ? {a1 - k * step, a2 - k * step} : {a1 + k * step, a2 + k * step};
      o_flags = {bus.seq_valid, bus.busy, bus.last_iter, bus.done, bus.iter_cnt_out};
      o_addr  = {bus.mem_addr1_out, bus.mem_addr2_out};
      tests++;
      if (o_flags !== e_flags) begin
        fails++;
        $display("FAIL %s flags k=%0d {vld,busy,last,done,cnt}: got %h want %h", tag, k, o_flags, e_flags);
      end
      if (e_flags[35]) begin
        tests++;
        if (o_addr !== e_addr) begin
          fails++;
          $display("FAIL %s addr k=%0d {a1,a2}: got %h want %h", tag, k, o_addr, e_addr);
        end
      end
      @(posedge clk);
      #1;
      exp_done = 1'b0;
      if (!stall) begin
        if (!rep) fin = 1'b1;
        else if (n == 0) begin
          fin = 1'b1;
          exp_done = 1'b1;
        end else begin
          k++;
          if (k == n) begin
            fin = 1'b1;
            exp_done = 1'b1;
          end
        end
      end
      guard++;
      if (!fin && guard > 500) begin
        tests++;
        fails++;
        $display("FAIL %s timeout: got no completion want completion within 500 cycles", tag);
        fin = 1'b1;
      end
    end
    bus.valid_in = 1'b0;
    bus.stall_in = 1'b0;
  endtask

  task automatic idle(input int cycles);
    logic [35:0] o;
    repeat (cycles) begin
      bus.valid_in = 1'b0;
      @(negedge clk);
      o = {bus.seq_valid, bus.busy, bus.last_iter, bus.done, bus.iter_cnt_out};
      tests++;
      if (o !== {3'b000, exp_done, 32'd0}) begin
        fails++;
        $display("FAIL idle {vld,busy,last,done,cnt}: got %h want %h", o, {3'b000, exp_done, 32'd0});
      end
      @(posedge clk);
      #1;
      exp_done = 1'b0;
    end
  endtask

  task automatic test_reset();
    logic [35:0] o;
    repeat (2) @(negedge clk);
    o = {bus.seq_valid, bus.busy, bus.last_iter, bus.done, bus.iter_cnt_out};
    tests++;
    if (o !== 36'd0) begin
      fails++;
      $display("FAIL reset outputs: got %h want %h", o, 36'd0);
    end
    clr = 1'b1;
    @(posedge clk);
    #1;
    exp_done = 1'b0;
    idle(1);
  endtask

  task automatic test_non_rep();
    exec_instr(1'b0, 32'd0, 2'b00, 1'b0, 32'h1000, 32'h1800, 0, 32'hFFFF_FFFF, 0, "non_rep");
    idle(1);
    for (int i = 0; i < 4; i++)
      exec_instr(1'b0, 32'd7, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 $urandom, $urandom, 40, 32'hFFFF_FFFF, 0, "non_rep_rand");
    idle(1);
  endtask

  task automatic test_rep_basic();
    exec_instr(1'b1, 32'd4, 2'b10, 1'b0, 32'h2000, 32'h3000, 0, 32'hFFFF_FFFF, 0, "rep4");
    idle(2);
  endtask

  task automatic test_wrap();
    exec_instr(1'b1, 32'd3, 2'b00, 1'b1, 32'h0000_0001, 32'h0000_0010, 0, 32'hFFFF_FFFF, 0, "wrap_dec");
    idle(1);
    exec_instr(1'b1, 32'd3, 2'b11, 1'b0, 32'hFFFF_FFF8, 32'h0, 0, 32'hFFFF_FFFF, 0, "wrap_inc");
    idle(1);
  endtask

  task automatic test_stall();
    exec_instr(1'b1, 32'd3, 2'b01, 1'b0, 32'h5000, 32'h6000, 0, 32'd1, 2, "stall_it2");
    idle(1);
    exec_instr(1'b1, 32'd1, 2'b01, 1'b0, 32'h5100, 32'h6100, 0, 32'd0, 2, "stall_single");
    idle(1);
  endtask

  task automatic test_rep_zero();
    exec_instr(1'b1, 32'd0, 2'b00, 1'b0, 32'h7000, 32'h7100, 0, 32'hFFFF_FFFF, 0, "rep_zero");
    idle(2);
    exec_instr(1'b1, 32'd0, 2'b00, 1'b0, 32'h7000, 32'h7100, 0, 32'd0, 2, "rep_zero_stall");
    idle(2);
  endtask

  task automatic test_flush();
    logic [34:0] o;
    bus.valid_in = 1'b1; bus.is_rep_in = 1'b1; bus.rep_num = 32'd5; bus.opsize_in = 2'b01;
    bus.df_in = 1'b0; bus.mem_addr1_in = 32'h100; bus.mem_addr2_in = 32'h200;
    bus.stall_in = 1'b0; bus.flush = 1'b0;
    @(negedge clk);
    tests++;
    if ({bus.seq_valid, bus.iter_cnt_out} !== {1'b1, 32'd4}) begin
      fails++;
      $display("FAIL flush_first {vld,cnt}: got %h want %h", {bus.seq_valid, bus.iter_cnt_out}, {1'b1, 32'd4});
    end
    @(posedge clk);
    #1;
    bus.flush = 1'b1;
    @(negedge clk);
    o = {bus.seq_valid, bus.busy, bus.last_iter, bus.iter_cnt_out};
    tests++;
    if (o !== 35'd0) begin
      fails++;
      $display("FAIL flush_cycle {vld,busy,last,cnt}: got %h want %h", o, 35'd0);
    end
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    bus.valid_in = 1'b0;
    exp_done = 1'b0;
    idle(2);
  endtask

  task automatic test_back_to_back();
    exec_instr(1'b1, 32'd1, 2'b10, 1'b0, 32'h8000, 32'h9000, 0, 32'hFFFF_FFFF, 0, "b2b_1");
    exec_instr(1'b1, 32'd3, 2'b10, 1'b1, 32'h8100, 32'h9100, 0, 32'hFFFF_FFFF, 0, "b2b_3");
    exec_instr(1'b0, 32'd0, 2'b00, 1'b0, 32'h8200, 32'h9200, 0, 32'hFFFF_FFFF, 0, "b2b_nonrep");
    exec_instr(1'b1, 32'd0, 2'b00, 1'b0, 32'h8300, 32'h9300, 0, 32'hFFFF_FFFF, 0, "b2b_0");
    exec_instr(1'b1, 32'd2, 2'b11, 1'b0, 32'h8400, 32'h9400, 0, 32'hFFFF_FFFF, 0, "b2b_2");
    idle(2);
  endtask

  task automatic test_reset_mid();
    logic [35:0] o;
    bus.valid_in = 1'b1; bus.is_rep_in = 1'b1; bus.rep_num = 32'd8; bus.opsize_in = 2'b11;
    bus.df_in = 1'b0; bus.mem_addr1_in = 32'h4000; bus.mem_addr2_in = 32'h5000;
    bus.stall_in = 1'b0; bus.flush = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    clr = 1'b0;
    bus.valid_in = 1'b0;
    #1;
    o = {bus.seq_valid, bus.busy, bus.last_iter, bus.done, bus.iter_cnt_out};
    tests++;
    if (o !== 36'd0) begin
      fails++;
      $display("FAIL reset_mid outputs: got %h want %h", o, 36'd0);
    end
    @(negedge clk);
    clr = 1'b1;
    @(posedge clk);
    #1;
    exp_done = 1'b0;
    idle(1);
    exec_instr(1'b1, 32'd2, 2'b10, 1'b0, 32'hA000, 32'hB000, 0, 32'hFFFF_FFFF, 0, "post_reset");
    idle(2);
  endtask

  task automatic test_random();
    bit          rep;
    logic [31:0] n, a1, a2;
    for (int i = 0; i < 40; i++) begin
      rep = ($urandom_range(0, 3) != 0);
      n   = $urandom_range(0, 6);
      a1  = ($urandom_range(0, 1) != 0) ? $urandom : (32'hFFFF_FFF0 + $urandom_range(0, 15));
      a2  = ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 15));
      exec_instr(rep, n, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), a1, a2,
                 25, 32'hFFFF_FFFF, 0, "random");
      if ($urandom_range(0, 4) == 0) idle(1);
    end
    idle(2);
  endtask

  initial begin
    clr = 1'b0;
    bus.valid_in = 1'b0; bus.is_rep_in = 1'b0; bus.rep_num = '0; bus.opsize_in = 2'b00;
    bus.df_in = 1'b0; bus.mem_addr1_in = '0; bus.mem_addr2_in = '0;
    bus.stall_in = 1'b0; bus.flush = 1'b0;
    test_reset();
    test_non_rep();
    test_rep_basic();
    test_wrap();
    test_stall();
    test_rep_zero();
    test_flush();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
